spi_master: RTL and testbench

- Byte-wide SPI initiator (master). Drives spi_clk, spi_ss and spi_out (MOSI), and samples spi_in (MISO).
- Peer of our spi_slave block. Used on the controller side to talk to external SPI peripherals, and on-chip/in-bench against spi_slave.
- Supports programmable clock polarity, phase and divider, and can keep SS asserted across back-to-back bytes.

---
 rtl/spi_master.sv | 130 +++++++++++++
 tb/tb_spi_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Byte-wide SPI initiator with programmable CPOL/CPHA and clock divider.
// Half SPI period T = clk_div+1 enabled cycles; SS can be held across bytes.
module spi_master #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 spi_clk_polarity,
    input  logic                 spi_clk_phase,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic                 start,
    input  logic                 hold_ss,
    input  logic [7:0]           bus_in,
    output logic [7:0]           bus_out,
    output logic                 busy,
    output logic                 tx,
    output logic                 rx,
    output logic                 spi_clk,
    output logic                 spi_ss,
    output logic                 spi_out,
    input  logic                 spi_in
);
    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e               state_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [4:0]           tog_q;
    logic                 cpha_q;
    logic [7:0]           tx_sh_q;
    logic [7:0]           rx_sh_q;
    logic                 tx_q;
    logic                 rx_q;
    logic                 cnt_wrap;
    logic                 lead;

    assign cnt_wrap = (cnt_q == div_q);
    // Next toggle is odd (leading) when the count so far is even.
    assign lead     = ~tog_q[0];

    // Strobes are held while frozen and only shown in enabled cycles.
    assign tx = tx_q & ena;
    assign rx = rx_q & ena;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= '0;
            tog_q   <= '0;
            cpha_q  <= 1'b0;
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            tx_q    <= 1'b0;
            rx_q    <= 1'b0;
            bus_out <= '0;
            busy    <= 1'b0;
            spi_clk <= 1'b0;
            spi_ss  <= 1'b1;
            spi_out <= 1'b0;
        end else if (ena) begin
            tx_q <= 1'b0;
            rx_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    spi_clk <= spi_clk_polarity;
                    cnt_q   <= '0;
                    tog_q   <= '0;
                    if (start) begin
                        div_q   <= clk_div;
                        cpha_q  <= spi_clk_phase;
                        tx_sh_q <= bus_in;
                        tx_q    <= 1'b1;
                        busy    <= 1'b1;
                        spi_ss  <= 1'b0;
                        if (!spi_clk_phase) begin
                            spi_out <= bus_in[7];
                        end
                        state_q <= StSetup;
                    end
                end
                StSetup, StShift: begin
                    cnt_q <= cnt_wrap ? '0 : cnt_q + 1'b1;
                    if (cnt_wrap) begin
                        if (state_q == StShift && tog_q == 5'd16) begin
                            state_q <= StHold;
                        end else begin
                            state_q <= StShift;
                            spi_clk <= ~spi_clk;
                            tog_q   <= tog_q + 1'b1;
                            if (lead ^ cpha_q) begin
                                rx_sh_q <= {rx_sh_q[6:0], spi_in};
                            end else if (cpha_q) begin
                                spi_out <= tx_sh_q[7];
                                tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                            end else if (tog_q != 5'd15) begin
                                spi_out <= tx_sh_q[6];
                                tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                            end
                        end
                    end
                end
                StHold: begin
                    cnt_q <= cnt_wrap ? '0 : cnt_q + 1'b1;
                    if (cnt_wrap) begin
                        bus_out <= rx_sh_q;
                        rx_q    <= 1'b1;
                        if (hold_ss) begin
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            spi_ss  <= 1'b1;
                            state_q <= StGap;
                        end
                    end
                end
                StGap: begin
                    cnt_q <= cnt_wrap ? '0 : cnt_q + 1'b1;
                    if (cnt_wrap) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback, behavioural slave, SS hold,
// clock-enable stretching and mid-transfer reset.
module tb_spi_master;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b1;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [7:0] clk_div = 8'd0;
    logic       start = 1'b0;
    logic       hold_ss = 1'b0;
    logic [7:0] bus_in = 8'd0;
    logic [7:0] bus_out;
    logic       busy, tx, rx, spi_clk, spi_ss, spi_out, spi_in;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Behavioural SPI slave (mode taken from cpol/cpha) or MOSI->MISO loopback.
    logic       loop_back = 1'b1;
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;
    logic [7:0] s_sh = 8'h00;
    logic       s_miso = 1'b0;
    logic       pclk = 1'b0;
    logic       pss = 1'b1;
    logic       lead;
    int         toggles = 0;

    assign spi_in = loop_back ? spi_out : s_miso;

    spi_master #(.DIV_WIDTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .ena              (ena),
        .spi_clk_polarity (cpol),
        .spi_clk_phase    (cpha),
        .clk_div          (clk_div),
        .start            (start),
        .hold_ss          (hold_ss),
        .bus_in           (bus_in),
        .bus_out          (bus_out),
        .busy             (busy),
        .tx               (tx),
        .rx               (rx),
        .spi_clk          (spi_clk),
        .spi_ss           (spi_ss),
        .spi_out          (spi_out),
        .spi_in           (spi_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(spi_clk or spi_ss) begin
        if (pss && !spi_ss) begin
            s_sh = s_tx;
            s_rx = 8'h00;
            if (!cpha) s_miso = s_sh[7];
        end
        if (spi_clk != pclk && !spi_ss) begin
            toggles = toggles + 1;
            lead = (spi_clk != cpol);
            if (lead == !cpha) begin
                s_rx = {s_rx[6:0], spi_out};
            end else if (cpha) begin
                s_miso = s_sh[7];
                s_sh   = {s_sh[6:0], 1'b0};
            end else begin
                s_sh   = {s_sh[6:0], 1'b0};
                s_miso = s_sh[7];
            end
        end
        pclk = spi_clk;
        pss  = spi_ss;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One byte transfer; returns at the cycle rx is seen. tog toggles ena every
    // cycle, poke re-requests start and alters clk_div mid-transfer.
    task automatic xfer(input logic [7:0] b, input logic hold, input logic tog,
                        input logic poke, output int lat, output int n_tx, output int n_rx);
        int         t0;
        int         ss_hi;
        bit         got;
        logic [7:0] saved_div;
        saved_div = clk_div;
        lat   = -1;
        n_tx  = 0;
        n_rx  = 0;
        ss_hi = 0;
        t0    = 0;
        got   = 1'b0;
        bus_in  = b;
        hold_ss = hold;
        start   = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (tx) begin
                got = 1'b1;
                t0  = cyc;
                n_tx++;
                check("ss_low_at_tx", {31'd0, spi_ss}, 32'd0);
            end
            if (tog) ena = ~ena;
        end
        start = 1'b0;
        if (!got) begin
            ena = 1'b1;
            check("tx_timeout", 32'd0, 32'd1);
            return;
        end
        got = 1'b0;
        for (int i = 1; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (tx) n_tx++;
            if (rx) begin
                got = 1'b1;
                lat = cyc - t0;
                n_rx++;
            end else if (spi_ss) begin
                ss_hi++;
            end
            if (poke) begin
                start   = (i >= 8 && i < 16);
                clk_div = (i >= 8 && i < 16) ? 8'd5 : saved_div;
            end
            if (tog && !got) ena = ~ena;
        end
        start   = 1'b0;
        clk_div = saved_div;
        ena     = 1'b1;
        if (!got) check("rx_timeout", 32'd0, 32'd1);
        check("ss_low_during_byte", ss_hi, 32'd0);
    endtask

    initial begin
        int lat, n_tx, n_rx, tb0, gap, n_rx_rst;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ss", {31'd0, spi_ss}, 32'd1);
        check("rst_clk", {31'd0, spi_clk}, 32'd0);
        check("rst_mosi", {31'd0, spi_out}, 32'd0);
        check("rst_bus_out", {24'd0, bus_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx", {31'd0, tx}, 32'd0);
        check("rst_rx", {31'd0, rx}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Loopback, CPOL=0 CPHA=1, T=1, 0xA5
        loop_back = 1'b1; cpol = 1'b0; cpha = 1'b1; clk_div = 8'd0;
        repeat (2) @(negedge clk);
        tb0 = toggles;
        xfer(8'hA5, 1'b0, 1'b0, 1'b0, lat, n_tx, n_rx);
        check("lb_latency", lat, 32'd18);
        check("lb_tx_count", n_tx, 32'd1);
        check("lb_rx_count", n_rx, 32'd1);
        check("lb_toggles", toggles - tb0, 32'd16);
        check("lb_mosi_bits", {24'd0, s_rx}, 32'hA5);
        check("lb_bus_out", {24'd0, bus_out}, 32'hA5);
        check("lb_ss_high_at_rx", {31'd0, spi_ss}, 32'd1);
        check("lb_busy_in_gap", {31'd0, busy}, 32'd1);
        check("lb_clk_idle", {31'd0, spi_clk}, 32'd0);
        @(negedge clk);
        check("lb_busy_after_gap", {31'd0, busy}, 32'd0);

        // CPOL=1 CPHA=0, T=4, slave returns 0x3C, master sends 0xC3
        loop_back = 1'b0; cpol = 1'b1; cpha = 1'b0; clk_div = 8'd3; s_tx = 8'h3C;
        repeat (3) @(negedge clk);
        check("m2_clk_idle_high", {31'd0, spi_clk}, 32'd1);
        tb0 = toggles;
        xfer(8'hC3, 1'b0, 1'b0, 1'b0, lat, n_tx, n_rx);
        check("m2_latency", lat, 32'd72);
        check("m2_toggles", toggles - tb0, 32'd16);
        check("m2_bus_out", {24'd0, bus_out}, 32'h3C);
        check("m2_slave_rx", {24'd0, s_rx}, 32'hC3);
        repeat (6) @(negedge clk);

        // CPOL=0 CPHA=1, T=4, slave returns 0x5A, master sends 0x96
        cpol = 1'b0; cpha = 1'b1; s_tx = 8'h5A;
        repeat (3) @(negedge clk);
        xfer(8'h96, 1'b0, 1'b0, 1'b0, lat, n_tx, n_rx);
        check("m1_bus_out", {24'd0, bus_out}, 32'h5A);
        check("m1_slave_rx", {24'd0, s_rx}, 32'h96);
        repeat (6) @(negedge clk);

        // Held SS across 0x11 then 0x22, T=2
        loop_back = 1'b1; clk_div = 8'd1;
        repeat (3) @(negedge clk);
        tb0 = toggles;
        xfer(8'h11, 1'b1, 1'b0, 1'b0, lat, n_tx, n_rx);
        check("hold1_tx_rx", n_tx + n_rx, 32'd2);
        check("hold1_bus_out", {24'd0, bus_out}, 32'h11);
        check("hold1_ss_low", {31'd0, spi_ss}, 32'd0);
        check("hold1_busy_low", {31'd0, busy}, 32'd0);
        xfer(8'h22, 1'b0, 1'b0, 1'b0, lat, n_tx, n_rx);
        check("hold2_tx_rx", n_tx + n_rx, 32'd2);
        check("hold2_bus_out", {24'd0, bus_out}, 32'h22);
        check("hold_toggles", toggles - tb0, 32'd32);
        gap = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            if (spi_ss) gap++;
            @(negedge clk);
        end
        check("hold_gap_len", gap, 32'd2);
        check("hold_gap_ss", {31'd0, spi_ss}, 32'd1);

        // ena toggled 50%, start and clk_div poked mid-byte, T=1
        clk_div = 8'd0;
        repeat (3) @(negedge clk);
        tb0 = toggles;
        xfer(8'h5C, 1'b0, 1'b1, 1'b1, lat, n_tx, n_rx);
        check("ena_latency", lat, 32'd36);
        check("ena_tx_count", n_tx, 32'd1);
        check("ena_toggles", toggles - tb0, 32'd16);
        check("ena_bus_out", {24'd0, bus_out}, 32'h5C);
        repeat (4) @(negedge clk);

        // Reset after toggle 7, T=4
        clk_div = 8'd3;
        repeat (3) @(negedge clk);
        bus_in = 8'hF0; hold_ss = 1'b0; start = 1'b1;
        tb0 = toggles;
        for (int i = 0; i < 600 && (toggles - tb0) < 7; i++) @(negedge clk);
        start = 1'b0;
        check("rst_mid_toggles", toggles - tb0, 32'd7);
        rst = 1'b0;
        #1;
        check("rst_mid_ss", {31'd0, spi_ss}, 32'd1);
        check("rst_mid_clk", {31'd0, spi_clk}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        n_rx_rst = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (rx) n_rx_rst++;
        end
        check("rst_mid_no_rx", n_rx_rst, 32'd0);
        check("rst_mid_bus_out", {24'd0, bus_out}, 32'h00);
        xfer(8'h69, 1'b0, 1'b0, 1'b0, lat, n_tx, n_rx);
        check("post_rst_latency", lat, 32'd72);
        check("post_rst_bus_out", {24'd0, bus_out}, 32'h69);
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
